load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning bus cycles to wait for bus_ack before a timeout fault (range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port req_valid  input  1  the MEM stage holds a valid instruction.
REQ-005 SHALL have port mem_read  input  1  control-word load flag.
REQ-006 SHALL have port mem_write  input  1  control-word store flag.
REQ-007 SHALL have port funct3  input  3  access size and sign code from the control word.
REQ-008 SHALL have port addr  input  32  effective byte address (ALU result).
REQ-009 SHALL have port wdata  input  32  store source register value.
REQ-010 SHALL have port stall  output  1  holds the pipeline; the inputs stay stable while it is high.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking completion of an access.
REQ-012 SHALL have port rd_data  output  32  extended load result, valid when done is 1.
REQ-013 SHALL have port fault  output  1  misalignment, illegal-op or timeout indication.
REQ-014 SHALL have ports bus_req out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32 (word bus request), and bus_ack in 1, bus_rdata in 32 (response).

Function
REQ-015 SHALL implement FSM states IDLE, REQ, RESP.
REQ-016 IDLE: an op is present when req_valid=1 and (mem_read | mem_write).
REQ-017 IDLE: SHALL accept an op that is legal and aligned, latch the bus fields, drive stall=1 combinationally and go to REQ.
REQ-018 Legal ops: loads with funct3 in {000,001,010,100,101}; stores with funct3 in {000,001,010}; mem_read and mem_write both 1 is illegal.
REQ-019 Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.
REQ-020 An illegal or misaligned op in IDLE SHALL drive fault=1 and stall=0 combinationally in the same cycle, issue no bus request and stay in IDLE.
REQ-021 Latched fields: bus_addr={addr[31:2],2'b00}; bus_we=mem_write.
REQ-022 bus_be: SB gives 4'b0001<<addr[1:0]; SH gives 0011 or 1100 per addr[1]; SW gives 1111; loads give the same mask.
REQ-023 bus_wdata: SB replicates wdata[7:0] four times; SH replicates wdata[15:0] twice; SW passes wdata unchanged.
REQ-024 REQ: bus_req=1 and stall=1; the bus fields SHALL stay constant until bus_ack.
REQ-025 REQ: bus_ack=1 SHALL capture bus_rdata and go to RESP, including an ack in the first REQ cycle.
REQ-026 Minimum latency: accept in cycle N, bus_ack in cycle N+1, done in cycle N+2.
REQ-027 Load extraction selects lane addr[1:0]: LB/LBU sign/zero-extend the byte; LH/LHU sign/zero-extend the halfword; LW passes the word; stores give rd_data=0.
REQ-028 RESP: done=1 and stall=0 for exactly one cycle, then return to IDLE; the held op SHALL NOT be reissued.
REQ-029 SHALL keep a 16-bit wait counter, cleared on entry to REQ and incremented each REQ cycle without ack.
REQ-030 When the counter reaches TIMEOUT_CYCLES-1 without ack, the FSM SHALL drop bus_req next cycle and enter RESP with fault=1, done=1, rd_data=0.
REQ-031 bus_ack SHALL be ignored in IDLE and RESP.
REQ-032 rd_data SHALL hold its value outside RESP.

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge, including mid-REQ, abandoning the bus transaction.
REQ-034 Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rd_data=0, counter=0; done=0, fault=0, stall=0 while rst=1.

Verification
REQ-035 LB addr=0x103, bus_rdata=0x80FF_FF7F, ack in first REQ cycle -> bus_addr=0x100, bus_be=1000, done at N+2, rd_data=0xFFFF_FF80.
REQ-036 SH addr=0x202, wdata=0x1234_ABCD, ack after 3 cycles -> bus_be=1100, bus_wdata=0xABCD_ABCD, bus_we=1, stall high 4 cycles, then a 1-cycle done.
REQ-037 LW addr=0x006 -> fault=1 and stall=0 same cycle, bus_req stays 0; LHU addr=0x006 is accepted normally.
REQ-038 TIMEOUT_CYCLES=4, no ack -> bus_req high 4 cycles, then a RESP cycle with fault=1, done=1, rd_data=0.
REQ-039 rst pulsed in the 2nd REQ cycle, late bus_ack arrives afterwards -> IDLE, bus_req=0, the ack is ignored and no done pulse occurs.
REQ-040 Back-to-back LBU 0x0 then SW 0x4, 1-cycle ack each -> two done pulses 3 cycles apart, no reissue of the first op.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store engine. Turns one MEM-stage instruction into a
//   single word-bus transaction. It builds the byte-enable mask, replicates
//   store data across the lanes, and extracts and extends load data. It
//   stalls the pipeline until the response arrives or the wait times out.
//
// Ports
//   clk, rst             clock and synchronous active-high reset
//   req_valid            MEM stage holds a valid instruction
//   mem_read, mem_write  load / store flags from the control word
//   funct3               access size and signedness code
//   addr                 effective byte address
//   wdata                store source value
//   stall                holds the pipeline while an access is in flight
//   done                 one-cycle completion pulse
//   rd_data              extended load result, valid with done
//   fault                misaligned / illegal op, or bus timeout
//   bus_req .. bus_wdata word bus request channel (registered)
//   bus_ack, bus_rdata   word bus response channel
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        timeout_q;

  logic op_present;
  logic op_ok;

  function automatic logic op_legal(input logic rd, input logic wr, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (rd && wr)
      ok = 1'b0;
    else if (rd)
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101);
    else if (wr)
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    return ok;
  endfunction

  function automatic logic op_aligned(input logic [1:0] size, input logic [1:0] lane);
    logic ok;
    case (size)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lane[0];
      2'b10:   ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      2'b00:   m = 4'b0001 << lane;
      2'b01:   m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // funct3[2] set means unsigned (LBU/LHU); otherwise the top bit of the
  // selected lane is replicated.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = d[8*lane +: 8];
    h = lane[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = d;
    endcase
    return r;
  endfunction

  assign op_present = req_valid & (mem_read | mem_write);
  assign op_ok      = op_legal(mem_read, mem_write, funct3) & op_aligned(funct3[1:0], addr[1:0]);

  // Accept/reject decisions are visible in the same IDLE cycle; everything
  // is suppressed while reset is asserted.
  assign stall = ~rst & (((state == IDLE) & op_present & op_ok) | (state == REQ));
  assign fault = ~rst & (((state == IDLE) & op_present & ~op_ok) | ((state == RESP) & timeout_q));
  assign done  = ~rst & (state == RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      rd_data   <= 32'd0;
      wait_cnt  <= 16'd0;
      timeout_q <= 1'b0;
      f3_q      <= 3'd0;
      lane_q    <= 2'd0;
    end else begin
      case (state)
        // IDLE -> REQ: latch the request fields once; they stay frozen until the ack
        IDLE: begin
          if (op_present && op_ok) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_write;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= be_mask(funct3[1:0], addr[1:0]);
            bus_wdata <= store_lanes(funct3[1:0], wdata);
            f3_q      <= funct3;
            lane_q    <= addr[1:0];
            wait_cnt  <= 16'd0;
            timeout_q <= 1'b0;
            state     <= REQ;
          end
        end
        // REQ -> RESP: on ack capture the response, or give up after the wait budget
        REQ: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            rd_data   <= bus_we ? 32'd0 : load_extract(f3_q, lane_q, bus_rdata);
            timeout_q <= 1'b0;
            state     <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            bus_req   <= 1'b0;
            rd_data   <= 32'd0;
            timeout_q <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        // RESP -> IDLE: the held instruction leaves the stage this cycle,
        // so it is not looked at again
        RESP: begin
          timeout_q <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
